// File: rtl/hr_mon_pkg.sv
`default_nettype none
// ============================================================================
// Package     : hr_mon_pkg
// Description : Shared types and helpers for the heartbeat-monitor session
//               controller: state encoding, age-based threshold maths and
//               the saturating increment.
// Revision    : 1.0 - initial release
// ============================================================================
package hr_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_MEASURE = 2'b01,
    ST_HOLD    = 2'b10
  } state_t;

  localparam int MAXHR_DEF = 220;

  // Thresholds are returned wide; callers truncate to their sample width.
  typedef struct packed {
    logic [15:0] min_v;
    logic [15:0] max_v;
  } thr_t;

  // Heart-rate band from age: d = max(0, maxhr-age); low = d/2; high = 0.85*d.
  function automatic thr_t thr_calc(input logic [9:0] age,
                                    input int unsigned maxhr = MAXHR_DEF);
    thr_t        r;
    int unsigned d;
    d       = (32'(age) >= maxhr) ? 32'd0 : (maxhr - 32'(age));
    r.min_v = 16'(d >> 1);
    r.max_v = 16'((d * 32'd85) / 32'd100);
    return r;
  endfunction

  // Increment that sticks at maxv instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v,
                                          input logic [31:0] maxv);
    return (v >= maxv) ? maxv : (v + 32'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hr_channel_stats.sv
`default_nettype none
// ============================================================================
// Module      : hr_channel_stats
// Description : Per-channel session statistics: sample accumulator, beat
//               count, saturating low/high violation counts, run-length
//               counters and sticky run-length alarms.
// Revision    : 1.0 - initial release
// ============================================================================
module hr_channel_stats
  import hr_mon_pkg::*;
#(
  parameter int BPM_W     = 8,
  parameter int CNT_W     = 8,
  parameter int WIN       = 16,
  parameter int ALARM_RUN = 3
)(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             clr_alarm,
  input  logic             enable,
  input  logic             valid,
  input  logic [BPM_W-1:0] bpm,
  input  logic [BPM_W-1:0] min_thr,
  input  logic [BPM_W-1:0] max_thr,
  output logic [CNT_W-1:0] beats,
  output logic [CNT_W-1:0] lo_viol,
  output logic [CNT_W-1:0] hi_viol,
  output logic             alarm_lo,
  output logic             alarm_hi,
  output logic             complete,
  output logic             complete_next,
  output logic [BPM_W-1:0] avg_next
);

  localparam int          SUM_W   = BPM_W + $clog2(WIN);
  localparam int          RUN_W   = $clog2(ALARM_RUN + 1);
  localparam logic [31:0] CNT_MAX = 32'((longint'(1) << CNT_W) - 1);

  logic [SUM_W-1:0] sum_q, sum_n;
  logic [CNT_W-1:0] beats_n, lo_n, hi_n;
  logic [RUN_W-1:0] run_lo, run_hi, run_lo_n, run_hi_n;
  logic             alarm_lo_n, alarm_hi_n;
  logic             accept, is_lo, is_hi;

  assign accept = enable && valid && (32'(beats) < 32'(WIN));
  assign is_lo  = bpm < min_thr;
  assign is_hi  = bpm > max_thr;

  // Next-state of every statistic for the current sample.
  always_comb begin
    sum_n      = sum_q;
    beats_n    = beats;
    lo_n       = lo_viol;
    hi_n       = hi_viol;
    run_lo_n   = run_lo;
    run_hi_n   = run_hi;
    alarm_lo_n = alarm_lo;
    alarm_hi_n = alarm_hi;
    if (accept) begin
      sum_n   = sum_q + SUM_W'(bpm);
      beats_n = CNT_W'(sat_inc(32'(beats), CNT_MAX));
      if (is_lo) begin
        lo_n     = CNT_W'(sat_inc(32'(lo_viol), CNT_MAX));
        run_lo_n = RUN_W'(sat_inc(32'(run_lo), 32'(ALARM_RUN)));
        run_hi_n = '0;
      end else if (is_hi) begin
        hi_n     = CNT_W'(sat_inc(32'(hi_viol), CNT_MAX));
        run_hi_n = RUN_W'(sat_inc(32'(run_hi), 32'(ALARM_RUN)));
        run_lo_n = '0;
      end else begin
        run_lo_n = '0;
        run_hi_n = '0;
      end
      if (32'(run_lo_n) == 32'(ALARM_RUN)) alarm_lo_n = 1'b1;
      if (32'(run_hi_n) == 32'(ALARM_RUN)) alarm_hi_n = 1'b1;
    end
  end

  // Completion is exposed both registered (end-of-window detect) and
  // look-ahead (so a sample on the ending edge still makes the average).
  assign complete      = (32'(beats) == 32'(WIN));
  assign complete_next = (32'(beats_n) == 32'(WIN));
  assign avg_next      = complete_next ? sum_n[SUM_W-1 -: BPM_W] : '0;

  // Statistic registers; clear wins over sampling, alarms clear only on request.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sum_q    <= '0;
      beats    <= '0;
      lo_viol  <= '0;
      hi_viol  <= '0;
      run_lo   <= '0;
      run_hi   <= '0;
      alarm_lo <= 1'b0;
      alarm_hi <= 1'b0;
    end else if (clear) begin
      sum_q   <= '0;
      beats   <= '0;
      lo_viol <= '0;
      hi_viol <= '0;
      run_lo  <= '0;
      run_hi  <= '0;
      if (clr_alarm) begin
        alarm_lo <= 1'b0;
        alarm_hi <= 1'b0;
      end
    end else begin
      sum_q    <= sum_n;
      beats    <= beats_n;
      lo_viol  <= lo_n;
      hi_viol  <= hi_n;
      run_lo   <= run_lo_n;
      run_hi   <= run_hi_n;
      alarm_lo <= alarm_lo_n;
      alarm_hi <= alarm_hi_n;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hr_monitor_session_mc.sv
`default_nettype none
// ============================================================================
// Module      : hr_monitor_session_mc
// Description : Multi-channel heartbeat-monitor session controller.
//               IDLE -> MEASURE -> HOLD session FSM, measure/hold timers,
//               age-based threshold latch and end-of-session result capture.
//               Per-channel statistics live in hr_channel_stats.
//               Optional macro HR_MON_CONTINUOUS_EN: HOLD restarts MEASURE
//               directly when start is high, keeping thresholds and alarms.
// Revision    : 1.0 - initial release
// ============================================================================
module hr_monitor_session_mc
  import hr_mon_pkg::*;
#(
  parameter int NCH       = 4,
  parameter int BPM_W     = 8,
  parameter int CNT_W     = 8,
  parameter int WIN       = 16,
  parameter int TIMEOUT   = 1000,
  parameter int HOLD_CYC  = 6,
  parameter int MAXHR     = MAXHR_DEF,
  parameter int ALARM_RUN = 3
)(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [9:0]           age,
  input  logic [NCH-1:0]       beat_valid,
  input  logic [NCH*BPM_W-1:0] beat_bpm,
  output logic                 measuring,
  output logic                 displaying,
  output logic                 done,
  output logic [BPM_W-1:0]     min_thr,
  output logic [BPM_W-1:0]     max_thr,
  output logic [NCH*BPM_W-1:0] avg,
  output logic [NCH*CNT_W-1:0] beats,
  output logic [NCH*CNT_W-1:0] lo_viol,
  output logic [NCH*CNT_W-1:0] hi_viol,
  output logic [NCH-1:0]       stale,
  output logic [NCH-1:0]       alarm_lo,
  output logic [NCH-1:0]       alarm_hi
);

  localparam int TMR_MAX = (TIMEOUT > HOLD_CYC) ? TIMEOUT : HOLD_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  state_t                    state;
  logic [TMR_W-1:0]          timer;
  thr_t                      thr;
  logic                      clear, clr_alarm, enable;
  logic                      meas_end, hold_end, restart;
  logic [NCH-1:0]            complete, complete_next;
  logic [NCH-1:0][BPM_W-1:0] avg_cap;

  assign thr      = thr_calc(age, MAXHR);
  assign hold_end = (state == ST_HOLD) && (32'(timer) == 32'(HOLD_CYC - 1));
  assign meas_end = (state == ST_MEASURE) &&
                    ((&complete) || (32'(timer) == 32'(TIMEOUT - 1)));

`ifdef HR_MON_CONTINUOUS_EN
  assign restart = hold_end && start;
`else
  assign restart = 1'b0;
`endif

  // A fresh start wipes alarms; a back-to-back restart keeps them sticky.
  assign clr_alarm = (state == ST_IDLE) && start;
  assign clear     = clr_alarm || restart;
  assign enable    = (state == ST_MEASURE);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    hr_channel_stats #(
      .BPM_W     (BPM_W),
      .CNT_W     (CNT_W),
      .WIN       (WIN),
      .ALARM_RUN (ALARM_RUN)
    ) u_stats (
      .clk           (clk),
      .reset         (reset),
      .clear         (clear),
      .clr_alarm     (clr_alarm),
      .enable        (enable),
      .valid         (beat_valid[i]),
      .bpm           (beat_bpm[i*BPM_W +: BPM_W]),
      .min_thr       (min_thr),
      .max_thr       (max_thr),
      .beats         (beats[i*CNT_W +: CNT_W]),
      .lo_viol       (lo_viol[i*CNT_W +: CNT_W]),
      .hi_viol       (hi_viol[i*CNT_W +: CNT_W]),
      .alarm_lo      (alarm_lo[i]),
      .alarm_hi      (alarm_hi[i]),
      .complete      (complete[i]),
      .complete_next (complete_next[i]),
      .avg_next      (avg_cap[i])
    );
  end

  // Session FSM with timers, threshold latch and registered result capture.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      timer      <= '0;
      measuring  <= 1'b0;
      displaying <= 1'b0;
      done       <= 1'b0;
      min_thr    <= '0;
      max_thr    <= '0;
      avg        <= '0;
      stale      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            min_thr   <= BPM_W'(thr.min_v);
            max_thr   <= BPM_W'(thr.max_v);
            avg       <= '0;
            stale     <= '0;
            timer     <= '0;
            measuring <= 1'b1;
            state     <= ST_MEASURE;
          end
        end
        ST_MEASURE: begin
          if (meas_end) begin
            for (int i = 0; i < NCH; i++) begin
              avg[i*BPM_W +: BPM_W] <= avg_cap[i];
              stale[i]              <= ~complete_next[i];
            end
            timer      <= '0;
            measuring  <= 1'b0;
            displaying <= 1'b1;
            done       <= 1'b1;
            state      <= ST_HOLD;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_HOLD: begin
          if (hold_end) begin
            timer      <= '0;
            displaying <= 1'b0;
            if (restart) begin
              avg       <= '0;
              stale     <= '0;
              measuring <= 1'b1;
              state     <= ST_MEASURE;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          timer      <= '0;
          measuring  <= 1'b0;
          displaying <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hr_monitor_session_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_hr_monitor_session_mc
// Description : Directed self-checking bench for hr_monitor_session_mc
//               (default build, HR_MON_CONTINUOUS_EN undefined). A second
//               narrow-counter instance covers counter saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hr_monitor_session_mc;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [9:0]  age;
  logic [3:0]  beat_valid;
  logic [31:0] beat_bpm;
  logic        measuring, displaying, done;
  logic [7:0]  min_thr, max_thr;
  logic [31:0] avg, beats, lo_viol, hi_viol;
  logic [3:0]  stale, alarm_lo, alarm_hi;

  logic        start2;
  logic [9:0]  age2;
  logic [0:0]  valid2;
  logic [7:0]  bpm2;
  logic        meas2, disp2, done2;
  logic [7:0]  min2, max2, avg2;
  logic [3:0]  beats2, lo2, hi2;
  logic [0:0]  stale2, alo2, ahi2;

  int n_cmp = 0;
  int n_err = 0;
  int cyc, dcnt;

  logic [7:0] pat [16] = '{8'd200, 8'd200, 8'd120, 8'd200, 8'd200, 8'd200, 8'd200, 8'd200,
                           8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100};

  always #5 clk = ~clk;

  hr_monitor_session_mc u_dut (
    .clk (clk), .reset (reset), .start (start), .age (age),
    .beat_valid (beat_valid), .beat_bpm (beat_bpm),
    .measuring (measuring), .displaying (displaying), .done (done),
    .min_thr (min_thr), .max_thr (max_thr), .avg (avg), .beats (beats),
    .lo_viol (lo_viol), .hi_viol (hi_viol), .stale (stale),
    .alarm_lo (alarm_lo), .alarm_hi (alarm_hi)
  );

  hr_monitor_session_mc #(.NCH(1), .CNT_W(4), .WIN(32), .TIMEOUT(64)) u_sat (
    .clk (clk), .reset (reset), .start (start2), .age (age2),
    .beat_valid (valid2), .beat_bpm (bpm2),
    .measuring (meas2), .displaying (disp2), .done (done2),
    .min_thr (min2), .max_thr (max2), .avg (avg2), .beats (beats2),
    .lo_viol (lo2), .hi_viol (hi2), .stale (stale2),
    .alarm_lo (alo2), .alarm_hi (ahi2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 20 && displaying; k++) tick();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start = 1'b0; age = '0; beat_valid = '0; beat_bpm = '0;
    start2 = 1'b0; age2 = '0; valid2 = '0; bpm2 = '0;
    repeat (3) tick();
    chk("rst_measuring", 32'(measuring), 32'd0);
    chk("rst_displaying", 32'(displaying), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_thr", {16'd0, min_thr, max_thr}, 32'd0);
    chk("rst_avg", avg, 32'd0);
    chk("rst_beats", beats, 32'd0);
    chk("rst_viol", lo_viol | hi_viol, 32'd0);
    chk("rst_flags", {20'd0, stale, alarm_hi, alarm_lo}, 32'd0);
    reset = 1'b1;
    tick();

    // Counter saturation on the narrow instance: 20 samples of 250, WIN=32.
    age2 = 10'd20; start2 = 1'b1; tick(); start2 = 1'b0;
    valid2 = 1'b1; bpm2 = 8'd250;
    repeat (20) tick();
    valid2 = 1'b0;
    chk("sat_beats", 32'(beats2), 32'd15);
    chk("sat_hi_viol", 32'(hi2), 32'd15);
    chk("sat_lo_viol", 32'(lo2), 32'd0);
    chk("sat_alarm_hi", 32'(ahi2), 32'd1);
    for (int k = 0; k < 100 && !disp2; k++) tick();
    chk("sat_timeout", 32'(disp2), 32'd1);
    chk("sat_stale", 32'(stale2), 32'd1);
    chk("sat_avg", 32'(avg2), 32'd0);

    // Session 1: age 20, 16 samples of 80 on every channel; strobes on the
    // start edge are ignored.
    age = 10'd20; start = 1'b1; beat_valid = 4'hF; beat_bpm = {4{8'd80}};
    tick(); start = 1'b0;
    chk("s1_measuring", 32'(measuring), 32'd1);
    chk("s1_thr", {16'd0, min_thr, max_thr}, {16'd0, 8'd100, 8'd170});
    chk("s1_start_ignored", beats, 32'd0);
    repeat (16) tick();
    beat_valid = 4'h0;
    chk("s1_beats", beats, 32'h10101010);
    chk("s1_lo_viol", lo_viol, 32'h10101010);
    chk("s1_hi_viol", hi_viol, 32'd0);
    chk("s1_alarm_lo", 32'(alarm_lo), 32'hF);
    chk("s1_no_done_yet", 32'(done), 32'd0);
    tick();
    chk("s1_done", 32'(done), 32'd1);
    chk("s1_displaying", 32'(displaying), 32'd1);
    chk("s1_avg", avg, 32'h50505050);
    chk("s1_stale", 32'(stale), 32'd0);
    start = 1'b1;
    tick();
    chk("s1_done_pulse", 32'(done), 32'd0);
    repeat (4) tick();
    chk("s1_hold_still", {30'd0, measuring, displaying}, 32'd1);
    tick();
    chk("s1_hold_to_idle", {30'd0, measuring, displaying}, 32'd0);
    chk("s1_avg_held", avg, 32'h50505050);
    start = 1'b0;

    // Session 2: age beyond MAXHR -> zero thresholds, every sample high.
    age = 10'd250; start = 1'b1; tick(); start = 1'b0;
    chk("s2_thr", {16'd0, min_thr, max_thr}, 32'd0);
    chk("s2_alarm_cleared", 32'(alarm_lo), 32'd0);
    beat_valid = 4'hF; beat_bpm = {4{8'd5}};
    repeat (16) tick();
    beat_valid = 4'h0;
    chk("s2_hi_viol", hi_viol, 32'h10101010);
    chk("s2_lo_viol", lo_viol, 32'd0);
    chk("s2_alarm_hi", 32'(alarm_hi), 32'hF);
    tick();
    chk("s2_done", 32'(done), 32'd1);
    chk("s2_avg", avg, 32'h05050505);
    wait_idle();
    chk("s2_idle", 32'(displaying), 32'd0);

    // Session 4: ch1 run broken by an in-band sample, then a full run.
    age = 10'd40; start = 1'b1; tick(); start = 1'b0;
    chk("s4_thr", {16'd0, min_thr, max_thr}, {16'd0, 8'd90, 8'd153});
    beat_valid = 4'hF;
    for (int k = 0; k < 16; k++) begin
      beat_bpm = {8'd100, 8'd100, pat[k], 8'd100};
      tick();
      if (k == 4) begin
        chk("s4_no_alarm", 32'(alarm_hi), 32'd0);
        chk("s4_hi_viol_4", 32'(hi_viol[15:8]), 32'd4);
      end
      if (k == 7) begin
        chk("s4_alarm_hi", 32'(alarm_hi), 32'h2);
        chk("s4_hi_viol_7", 32'(hi_viol[15:8]), 32'd7);
      end
    end
    beat_valid = 4'h0;
    tick();
    chk("s4_done", 32'(done), 32'd1);
    chk("s4_avg", avg, 32'h64649164);
    chk("s4_lo_viol", lo_viol, 32'd0);
    wait_idle();

    // Session 3: ch0 short of samples -> timeout, ch0 stale.
    age = 10'd40; start = 1'b1; tick(); start = 1'b0;
    beat_bpm = {8'd100, 8'd100, 8'd100, 8'd120};
    beat_valid = 4'hF; repeat (8) tick();
    beat_valid = 4'hE; repeat (8) tick();
    beat_valid = 4'h0;
    cyc = 16; dcnt = 0;
    while (!displaying && cyc < 1100) begin
      tick(); cyc++;
      if (done) dcnt++;
    end
    repeat (3) begin
      tick();
      if (done) dcnt++;
    end
    chk("s3_timeout_cycle", 32'(cyc), 32'd1000);
    chk("s3_done_once", 32'(dcnt), 32'd1);
    chk("s3_beats", beats, 32'h10101008);
    chk("s3_stale", 32'(stale), 32'h1);
    chk("s3_avg", avg, 32'h64646400);
    wait_idle();

    // Session 6: reset mid-MEASURE aborts with no done pulse.
    age = 10'd20; start = 1'b1; tick(); start = 1'b0;
    beat_valid = 4'hF; beat_bpm = {4{8'd80}};
    repeat (3) tick();
    chk("s6_beats_pre", beats, 32'h03030303);
    reset = 1'b0; tick();
    beat_valid = 4'h0;
    chk("s6_measuring", 32'(measuring), 32'd0);
    chk("s6_beats", beats, 32'd0);
    chk("s6_thr", {16'd0, min_thr, max_thr}, 32'd0);
    chk("s6_lo_viol", lo_viol, 32'd0);
    chk("s6_alarm", {28'd0, alarm_lo}, 32'd0);
    reset = 1'b1;
    dcnt = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (done) dcnt++;
    end
    chk("s6_no_done", 32'(dcnt), 32'd0);
    chk("s6_idle", {30'd0, measuring, displaying}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
